// File: rtl/vcm_af_sweep_if.sv
// Handshake between the autofocus sweep controller and the VCM I2C writer.
// The controller (master) raises WR_REQ with WR_DATA and holds both until
// the writer (slave) answers with WR_ACK.
interface vcm_af_sweep_if;
    logic        WR_REQ;
    logic [15:0] WR_DATA;
    logic        WR_ACK;

    modport master (output WR_REQ, output WR_DATA, input WR_ACK);
    modport slave  (input WR_REQ, input WR_DATA, output WR_ACK);
endinterface

// File: rtl/vcm_af_sweep.sv
// Voice-coil-motor autofocus sweep controller.
// Steps the lens through positions 0, STEP_SIZE, 2*STEP_SIZE, ... (saturating
// at 1023), writes each position to the VCM, waits SETTLE_FRAMES frame
// pulses, records the per-frame sharpness, and finally parks the lens at the
// sharpest position found (earliest position wins on ties).
// Optional feature: define VCM_AF_ACK_TIMEOUT_EN to add a 20-bit watchdog on
// the write handshake that raises a sticky ERR when the writer never answers.
module vcm_af_sweep #(
    parameter int STEP_SIZE     = 16,
    parameter int N_STEPS       = 64,
    parameter int SETTLE_FRAMES = 2
) (
    input  logic                  CLK_50,
    input  logic                  RESET,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic                  VS,
    input  logic                  SHARP_VALID,
    input  logic [23:0]           SHARP,
    vcm_af_sweep_if.master        wr,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR,
    output logic [9:0]            STEP,
    output logic [9:0]            BEST_POS
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_SETTLE,
        S_MEASURE,
        S_NEXT,
        S_FINAL,
        S_END
    } state_t;

    localparam logic [3:0]  SETTLE_N  = SETTLE_FRAMES[3:0];
    localparam logic [10:0] N_MEAS    = N_STEPS[10:0];
    localparam logic [10:0] STEP_INC  = {3'b000, STEP_SIZE[7:0]};
    localparam logic [9:0]  POS_MAX   = 10'h3FF;

    state_t       state_q, state_d;
    logic         wr_req_q, wr_req_d;
    logic [15:0]  wr_data_q, wr_data_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [9:0]   step_q, step_d;
    logic [9:0]   best_pos_q, best_pos_d;
    logic [23:0]  best_q, best_d;
    logic [3:0]   settle_cnt_q, settle_cnt_d;
    logic [10:0]  meas_cnt_q, meas_cnt_d;

`ifdef VCM_AF_ACK_TIMEOUT_EN
    // Watchdog fires on the (2^20-1)-th cycle of WR_REQ without an answer.
    localparam logic [19:0] WD_LAST = 20'hFFFFE;
    logic         err_q, err_d;
    logic [19:0]  wd_q, wd_d;
`endif

    // An ACK only counts while a request is actually outstanding.
    logic         ack_seen;
    logic [10:0]  step_sum;
    logic [9:0]   step_sat;

    assign ack_seen = wr_req_q & wr.WR_ACK;
    assign step_sum = {1'b0, step_q} + STEP_INC;
    assign step_sat = (step_sum > {1'b0, POS_MAX}) ? POS_MAX : step_sum[9:0];

    // Next-state and next-output computation for the sweep sequencer.
    always_comb begin
        state_d      = state_q;
        wr_req_d     = wr_req_q;
        wr_data_d    = wr_data_q;
        done_d       = 1'b0;
        step_d       = step_q;
        best_pos_d   = best_pos_q;
        best_d       = best_q;
        settle_cnt_d = settle_cnt_q;
        meas_cnt_d   = meas_cnt_q;
`ifdef VCM_AF_ACK_TIMEOUT_EN
        err_d        = err_q;
        wd_d         = wr_req_q ? (wd_q + 20'd1) : 20'd0;
`endif

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    step_d     = 10'd0;
                    best_d     = 24'd0;
                    best_pos_d = 10'd0;
                    meas_cnt_d = 11'd0;
                    wr_req_d   = 1'b1;
                    wr_data_d  = 16'h0000;
                    state_d    = S_WRITE;
`ifdef VCM_AF_ACK_TIMEOUT_EN
                    err_d      = 1'b0;
`endif
                end
            end
            S_WRITE: begin
                if (ack_seen) begin
                    wr_req_d     = 1'b0;
                    settle_cnt_d = 4'd0;
                    state_d      = (SETTLE_N == 4'd0) ? S_MEASURE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (VS) begin
                    if (settle_cnt_q + 4'd1 == SETTLE_N) begin
                        state_d = S_MEASURE;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 4'd1;
                    end
                end
            end
            S_MEASURE: begin
                if (SHARP_VALID) begin
                    meas_cnt_d = meas_cnt_q + 11'd1;
                    // Strict compare: an equal later reading never displaces
                    // the earlier (lower) position.
                    if (SHARP > best_q) begin
                        best_d     = SHARP;
                        best_pos_d = step_q;
                    end
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                wr_req_d = 1'b1;
                if (meas_cnt_q == N_MEAS || step_q == POS_MAX) begin
                    wr_data_d = {2'b00, best_pos_q, 4'h0};
                    state_d   = S_FINAL;
                end else begin
                    step_d    = step_sat;
                    wr_data_d = {2'b00, step_sat, 4'h0};
                    state_d   = S_WRITE;
                end
            end
            S_FINAL: begin
                if (ack_seen) begin
                    wr_req_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_END;
                end
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                wr_req_d = 1'b0;
            end
        endcase

`ifdef VCM_AF_ACK_TIMEOUT_EN
        // Writer never answered: give up on the sweep without a DONE.
        if (wr_req_q && !ack_seen && wd_q == WD_LAST) begin
            wr_req_d = 1'b0;
            err_d    = 1'b1;
            done_d   = 1'b0;
            state_d  = S_IDLE;
        end
`endif

        // ABORT outranks START, ACK and everything else in the same cycle.
        if (ABORT) begin
            state_d  = S_IDLE;
            wr_req_d = 1'b0;
            done_d   = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLK_50 or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            wr_req_q     <= 1'b0;
            wr_data_q    <= 16'h0000;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            step_q       <= 10'd0;
            best_pos_q   <= 10'd0;
            best_q       <= 24'd0;
            settle_cnt_q <= 4'd0;
            meas_cnt_q   <= 11'd0;
        end else begin
            state_q      <= state_d;
            wr_req_q     <= wr_req_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            step_q       <= step_d;
            best_pos_q   <= best_pos_d;
            best_q       <= best_d;
            settle_cnt_q <= settle_cnt_d;
            meas_cnt_q   <= meas_cnt_d;
        end
    end

`ifdef VCM_AF_ACK_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge CLK_50 or posedge RESET) begin
        if (RESET) begin
            err_q <= 1'b0;
            wd_q  <= 20'd0;
        end else begin
            err_q <= err_d;
            wd_q  <= wd_d;
        end
    end
    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    assign wr.WR_REQ  = wr_req_q;
    assign wr.WR_DATA = wr_data_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign STEP       = step_q;
    assign BEST_POS   = best_pos_q;

endmodule
